// File: rtl/c_deskew_buf.sv
// c_deskew_buf
//   Removes the per-lane skew from the result lanes of the systolic array,
//   assembles aligned rows into a DIM x DIM row buffer and serves one row per
//   read request, narrowed from BITS_C to BITS_OUT per element.
//
// Ports
//   clk    : clock
//   rst_n  : synchronous active-low reset (clears skew lines, buffer, Cout)
//   en     : shift enable; skew lines, collect counter and FSM advance only when high
//   start  : first-element marker, honoured only with en=1
//   Cin    : DIM skewed lanes of BITS_C bits; lane j carries element (r,j) in en-cycle r+j
//   rd_en  : read request, served only while done=1
//   Crow   : row address of the read
//   Cout   : registered read data, DIM elements of BITS_OUT bits
//   busy   : collecting a matrix
//   done   : buffer holds a complete matrix
//
// Configuration
//   CDESKEW_SAT_EN : when defined, narrowing saturates to the signed BITS_OUT
//                    range; otherwise it keeps the low BITS_OUT bits.
//                    BITS_OUT >= BITS_C sign-extends in both builds.

module c_deskew_buf #(
  parameter int BITS_C   = 16,
  parameter int BITS_OUT = 8,
  parameter int DIM      = 8
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    en,
  input  logic                                    start,
  input  logic [DIM-1:0][BITS_C-1:0]              Cin,
  input  logic                                    rd_en,
  input  logic [((DIM > 1) ? $clog2(DIM) : 1)-1:0] Crow,
  output logic [DIM-1:0][BITS_OUT-1:0]            Cout,
  output logic                                    busy,
  output logic                                    done
);

  localparam int AW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int CW = $clog2(2 * DIM);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    READY   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   cur;
  logic            step;
  logic            wr_en;
  logic [AW-1:0]   wr_row;

  logic [BITS_C-1:0]             aligned [DIM];
  logic [DIM-1:0][BITS_C-1:0]    rowbuf  [DIM];

  // ---------------------------------------------------------------------------
  // Deskew lines: lane j is delayed by DIM-1-j en-gated stages so that every
  // lane presents row r in en-cycle r+DIM-1.
  // ---------------------------------------------------------------------------
  for (genvar j = 0; j < DIM; j++) begin : g_lane
    if (j == DIM - 1) begin : g_direct
      assign aligned[j] = Cin[j];
    end else begin : g_dly
      localparam int unsigned N = DIM - 1 - j;
      logic [BITS_C-1:0] sr [N];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int unsigned k = 0; k < N; k++) sr[k] <= '0;
        end else if (en) begin
          sr[0] <= Cin[j];
          for (int unsigned k = 1; k < N; k++) sr[k] <= sr[k-1];
        end
      end

      assign aligned[j] = sr[N-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Collect FSM.
  // cur is the count belonging to the current en-cycle. The start cycle is
  // en-cycle 0, so cur is forced to 0 there and the register then holds 1;
  // this keeps cur equal to the en-cycle index, which is what lines the row
  // writes up with the skew-line outputs.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cur     = cnt_q;
    step    = 1'b0;
    wr_en   = 1'b0;
    wr_row  = '0;

    case (state_q)
      IDLE, READY: begin
        if (en && start) begin
          state_d = COLLECT;
          cur     = '0;
          step    = 1'b1;
        end
      end
      COLLECT: begin
        if (en) begin
          if (start) cur = '0;  // restart: partial rows are simply rewritten
          step = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (step) begin
      cnt_d = cur + 1'b1;
      if (cur >= CW'(DIM - 1)) begin
        wr_en  = 1'b1;
        wr_row = AW'(cur - CW'(DIM - 1));
      end
      if (cur == CW'(2 * DIM - 2)) begin
        state_d = READY;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    busy = (state_q == COLLECT);
    done = (state_q == READY);
  end

  // ---------------------------------------------------------------------------
  // Row buffer, full BITS_C precision.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < DIM; r++) rowbuf[r] <= '0;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < DIM; i++) rowbuf[wr_row][i] <= aligned[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Read path narrowing.
  // ---------------------------------------------------------------------------
`ifdef CDESKEW_SAT_EN
  localparam int OW = (BITS_OUT < BITS_C) ? BITS_OUT : BITS_C;
  localparam logic signed [BITS_C-1:0] SAT_MAX = {{(BITS_C-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [BITS_C-1:0] SAT_MIN = {{(BITS_C-OW+1){1'b1}}, {(OW-1){1'b0}}};
`endif

  function automatic logic [BITS_OUT-1:0] narrow(input logic signed [BITS_C-1:0] s);
    // A signed operand makes the cast sign-extend when widening.
    if (BITS_OUT >= BITS_C) return BITS_OUT'(s);
`ifdef CDESKEW_SAT_EN
    if (s > SAT_MAX) return BITS_OUT'(SAT_MAX);
    if (s < SAT_MIN) return BITS_OUT'(SAT_MIN);
`endif
    return BITS_OUT'(s);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Cout <= '0;
    end else if (rd_en && (state_q == READY)) begin
      if ({1'b0, Crow} < (AW+1)'(DIM)) begin
        for (int unsigned i = 0; i < DIM; i++) Cout[i] <= narrow(rowbuf[Crow][i]);
      end else begin
        Cout <= '0;
      end
    end
  end

endmodule

// File: doc/c_deskew_buf.md
# c_deskew_buf

Output-side counterpart of the A-operand skew memory: it takes the skewed result lanes coming out of the tpumac systolic array and removes the per-lane delay. It assembles whole aligned result rows and holds the finished DIM x DIM matrix in a row buffer. Software or the next layer reads that buffer back one row per request, narrowed to the output width.

## Interface
Parameters:
- BITS_C, 16, width of each accumulator lane arriving from the array (signed)
- BITS_OUT, 8, width of each element returned on the read port (signed)
- DIM, 8, array dimension: lane count, row count and skew depth

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset; sampled on rising clk
- en  in  1  shift enable; all skew lines and the collect counter advance only when en=1
- start  in  1  first-element marker; valid only together with en=1; lane 0 carries row 0 in that cycle
- Cin  in  [BITS_C-1:0] x DIM  skewed lanes; lane j carries element (r,j) in en-cycle r+j
- rd_en  in  1  read request
- Crow  in  $clog2(DIM)  row address for the read
- Cout  out  [BITS_OUT-1:0] x DIM  registered read data, one aligned row
- busy  out  1  high in COLLECT
- done  out  1  high in READY; buffer holds a complete matrix

## Operation
- Deskew: lane j passes through DIM-1-j en-gated register stages.
  - Lane DIM-1 is direct (0 stages). Lane 0 has DIM-1 stages.
  - Row r is aligned at the skew-line outputs in en-cycle r+DIM-1, counted from start = cycle 0.
- Collect counter cnt, width $clog2(2*DIM):
  - Cleared to 0 by start.
  - Increments on each en cycle in COLLECT.
  - When cnt is in DIM-1..2*DIM-2 and en=1, the aligned row is written to buffer[cnt-(DIM-1)].
- States:
  - IDLE: start&en -> COLLECT, cnt=0.
  - COLLECT: the en cycle with cnt=2*DIM-2 writes row DIM-1 -> READY. start&en restarts: cnt=0, partial rows discarded, stay in COLLECT.
  - READY: start&en -> COLLECT, done drops the next cycle. Buffer contents remain readable until overwritten row by row.
- start without en is ignored in every state.
- Read:
  - rd_en=1 in READY loads Cout from buffer[Crow] on the next edge.
  - rd_en in IDLE or COLLECT is ignored; Cout holds its previous value.
  - Crow >= DIM (non-power-of-two DIM) returns all zeros.
- Narrowing BITS_C -> BITS_OUT is applied on the read path only. The buffer stores the full BITS_C.
- Reset values: Cout all 0, busy=0, done=0, state IDLE, cnt=0. All skew stages and all buffer rows are cleared to 0.
- Reset asserted mid-COLLECT or mid-READY aborts immediately: outputs go to the reset values on the same edge.

## Timing
- Latency from start to done: 2*DIM-1 en cycles. With en held high, done rises at the edge after the en cycle with cnt=2*DIM-2 (2*DIM-1 edges after the start edge).
- en=0 stalls the block: no shift, no count, no write, no state change. Gaps may be of any length.
- Read latency: 1 cycle. A read of Crow=k issued in the same cycle that READY is entered is ignored; the first valid read is the cycle after done=1.
- READY with start&en and rd_en in the same cycle: the read is served from the old contents, and the state moves to COLLECT.
- busy and done are never high together.

## Configuration
- CDESKEW_SAT_EN defined: each element is saturated to the signed BITS_OUT range. Values above the maximum return 2^(BITS_OUT-1)-1; values below the minimum return -2^(BITS_OUT-1).
- CDESKEW_SAT_EN undefined: each element is truncated to its low BITS_OUT bits (two's-complement wrap).
- When BITS_OUT >= BITS_C, the element is sign-extended in both builds.

## Test plan
All scenarios use DIM=8, BITS_C=16, BITS_OUT=8.
- Reset then idle: Cout=0, busy=0, done=0. rd_en with Crow=3 leaves Cout=0.
- Full skewed matrix with element (r,j)=r*8+j, en held high: done rises 15 edges after start. Reading Crow=0..7 returns row r = {r*8+0..r*8+7}.
- Same matrix with en low every other cycle: identical buffer contents; done rises after 15 en cycles.
- Element (2,5)=300 and element (4,1)=-300:
  - CDESKEW_SAT_EN defined: 127 and -128.
  - CDESKEW_SAT_EN undefined: 44 and -44 (low byte).
- Restart: start&en at cnt=6 in COLLECT, then a full new matrix with all elements 7: every row reads back all 7s, with no residue from the first matrix.
- Reset at cnt=10: done=0 and busy=0 on the next cycle; Cout=0. A subsequent clean matrix collects normally.
